// File: rtl/noc_flit_if_skid_fifo_if.sv
// NoC configuration package and the valid/ready flit interface shared by the skid FIFO.
package noc_flit_if_skid_fifo_pkg;

   typedef struct packed {
      logic [15:0] dest_w;
      logic [15:0] payload_w;
   } noc_cfg_t;

   localparam noc_cfg_t NOC_DEFAULT_CONFIG = '{dest_w: 16'd8, payload_w: 16'd24};

   // Flit width derived from the NoC configuration
   function automatic int unsigned flit_w(noc_cfg_t cfg);
      return 32'(cfg.dest_w) + 32'(cfg.payload_w);
   endfunction

endpackage

interface noc_flit_if #(
   parameter int unsigned FLIT_W =
      noc_flit_if_skid_fifo_pkg::flit_w(noc_flit_if_skid_fifo_pkg::NOC_DEFAULT_CONFIG)
);
   logic              valid;
   logic              ready;
   logic [FLIT_W-1:0] flit;

   modport master (output valid, output flit, input ready);
   modport slave  (input valid, input flit, output ready);
endinterface

// File: rtl/noc_flit_if_skid_fifo.sv
// FWFT flit FIFO terminating a registered-ready link; keeps SLACK entries free
// so flits launched after ready drops are still absorbed.
module noc_flit_if_skid_fifo
   import noc_flit_if_skid_fifo_pkg::*;
#(
   parameter noc_cfg_t    CONFIG = NOC_DEFAULT_CONFIG,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned SLACK  = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   noc_flit_if.slave                    flit_in_if,
   noc_flit_if.master                   flit_out_if,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         overflow
);

   localparam int unsigned FLIT_W  = flit_w(CONFIG);
   localparam int unsigned PTR_W   = $clog2(DEPTH);
   localparam int unsigned COUNT_W = $clog2(DEPTH+1);

   logic [FLIT_W-1:0]  mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic               valid_q;
   logic               ready_q;

   logic               full_c;
   logic               pop_c;
   logic               push_c;
   logic               drop_c;
   logic [COUNT_W-1:0] count_next_c;

   // Handshake decode; push ignores our own ready since upstream never holds its flit
   always_comb begin
      full_c       = (count == COUNT_W'(DEPTH));
      pop_c        = valid_q && flit_out_if.ready;
      push_c       = flit_in_if.valid && (!full_c || pop_c);
      drop_c       = flit_in_if.valid && full_c && !pop_c;
      count_next_c = count;
      if (push_c && !pop_c) begin
         count_next_c = count + COUNT_W'(1);
      end else if (pop_c && !push_c) begin
         count_next_c = count - COUNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         valid_q  <= 1'b0;
         ready_q  <= 1'b1;
         overflow <= 1'b0;
      end else begin
         count   <= count_next_c;
         valid_q <= (count_next_c != '0);
         ready_q <= ((COUNT_W'(DEPTH) - count_next_c) > COUNT_W'(SLACK));
         if (push_c) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop_c) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (drop_c) begin
            overflow <= 1'b1;
         end
      end
   end

   // Storage carries no reset; only entries behind valid count are ever observed
   always_ff @(posedge clk) begin
      if (push_c) begin
         mem[wr_ptr] <= flit_in_if.flit;
      end
   end

   assign flit_in_if.ready  = ready_q;
   assign flit_out_if.valid = valid_q;
   assign flit_out_if.flit  = valid_q ? mem[rd_ptr] : '0;

   a_valid_needs_data: assert property (@(posedge clk) disable iff (!rst_n)
      flit_out_if.valid |-> (count != '0));

endmodule

// File: tb/tb_noc_flit_if_skid_fifo.sv
// Self-checking bench: directed scenarios plus a randomized slicer-fed stream,
// all compared against a queue-based model of the FIFO.
module tb_noc_flit_if_skid_fifo;
   import noc_flit_if_skid_fifo_pkg::*;

   localparam int unsigned W     = flit_w(NOC_DEFAULT_CONFIG);
   localparam int unsigned DEPTH = 4;
   localparam int unsigned SLACK = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] count;
   logic       overflow;

   noc_flit_if #(.FLIT_W(W)) in_if ();
   noc_flit_if #(.FLIT_W(W)) out_if ();

   noc_flit_if_skid_fifo #(
      .CONFIG (NOC_DEFAULT_CONFIG),
      .DEPTH  (DEPTH),
      .SLACK  (SLACK)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flit_in_if  (in_if),
      .flit_out_if (out_if),
      .count       (count),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   logic [W-1:0] mq [$];
   bit           m_ovf;
   int           errors = 0;
   int           checks = 0;

   function automatic bit exp_ready();
      return (int'(DEPTH) - mq.size()) > int'(SLACK);
   endfunction

   function automatic logic [W-1:0] exp_flit();
      return (mq.size() != 0) ? mq[0] : '0;
   endfunction

   // One clock edge: apply the FIFO rules to the model, then settle past the edge
   task automatic step();
      bit           pop;
      bit           push;
      logic [W-1:0] d;
      pop  = (mq.size() != 0) && out_if.ready;
      push = in_if.valid;
      d    = in_if.flit;
      @(posedge clk);
      if (pop) void'(mq.pop_front());
      if (push) begin
         if (mq.size() < DEPTH) mq.push_back(d);
         else m_ovf = 1'b1;
      end
      #1;
   endtask

   task automatic do_reset();
      in_if.valid  = 1'b0;
      in_if.flit   = '0;
      out_if.ready = 1'b0;
      rst_n        = 1'b0;
      mq.delete();
      m_ovf = 1'b0;
      #13;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic fill(output logic [W-1:0] vals [4]);
      out_if.ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         vals[i]     = W'($urandom);
         in_if.valid = 1'b1;
         in_if.flit  = vals[i];
         step();
      end
      in_if.valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
      checks++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_if.valid); end
      checks++; if (in_if.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_if.ready); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
      checks++; if (out_if.flit !== '0) begin errors++; $display("FAIL reset_flit got %h want 0", out_if.flit); end
   endtask

   task automatic test_single_flit();
      logic [W-1:0] a;
      a            = W'($urandom);
      out_if.ready = 1'b1;
      in_if.valid  = 1'b1;
      in_if.flit   = a;
      step();
      in_if.valid = 1'b0;
      checks++; if (out_if.valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", out_if.valid); end
      checks++; if (out_if.flit !== a) begin errors++; $display("FAIL single_flit got %h want %h", out_if.flit, a); end
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got %0d want 1", count); end
      step();
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_popped_count got %0d want 0", count); end
      checks++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL single_popped_valid got %b want 0", out_if.valid); end
   endtask

   task automatic test_fill_drain();
      out_if.ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         in_if.valid = 1'b1;
         in_if.flit  = W'(i);
         step();
         checks++; if (count !== 3'(i)) begin errors++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i); end
         checks++; if (in_if.ready !== ((4 - i) > 2)) begin errors++; $display("FAIL fill_ready[%0d] got %b want %b", i, in_if.ready, (4 - i) > 2); end
      end
      in_if.valid = 1'b0;
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_overflow got %b want 0", overflow); end
      out_if.ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         checks++; if (out_if.valid !== 1'b1 || out_if.flit !== W'(i)) begin errors++; $display("FAIL drain_order[%0d] got v=%b %h want v=1 %h", i, out_if.valid, out_if.flit, W'(i)); end
         step();
      end
      checks++; if (out_if.valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL drain_empty got v=%b cnt=%0d want v=0 cnt=0", out_if.valid, count); end
   endtask

   task automatic test_full_push_pop();
      logic [W-1:0] vals [4];
      logic [W-1:0] x;
      logic [W-1:0] want [4];
      fill(vals);
      x            = W'($urandom);
      out_if.ready = 1'b1;
      in_if.valid  = 1'b1;
      in_if.flit   = x;
      step();
      in_if.valid = 1'b0;
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL pushpop_count got %0d want 4", count); end
      want = '{vals[1], vals[2], vals[3], x};
      for (int i = 0; i < 4; i++) begin
         checks++; if (out_if.flit !== want[i]) begin errors++; $display("FAIL pushpop_order[%0d] got %h want %h", i, out_if.flit, want[i]); end
         step();
      end
   endtask

   task automatic test_overflow();
      logic [W-1:0] vals [4];
      fill(vals);
      in_if.valid = 1'b1;
      in_if.flit  = ~vals[0];
      step();
      in_if.valid = 1'b0;
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d want 4", count); end
      step(); step();
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
      out_if.ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++; if (out_if.flit !== vals[i]) begin errors++; $display("FAIL ovf_contents[%0d] got %h want %h", i, out_if.flit, vals[i]); end
         step();
      end
      checks++; if (overflow !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL ovf_after_drain got ovf=%b cnt=%0d want ovf=1 cnt=0", overflow, count); end
      do_reset();
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_cleared got %b want 0", overflow); end
   endtask

   // Upstream behaves like the slicer: it acts on a ready that is one cycle stale
   task automatic test_random_stream();
      int send_seq = 0;
      int recv_seq = 0;
      bit r_prev   = 1'b1;
      bit src_on   = 1'b1;
      for (int cyc = 0; cyc < 10040; cyc++) begin
         if (cyc == 10000) src_on = 1'b0;
         if (cyc == 6000) begin
            #2;
            rst_n = 1'b0;
            #1;
            checks++; if (count !== 3'd0 || out_if.valid !== 1'b0 || in_if.ready !== 1'b1 || out_if.flit !== '0) begin
               errors++; $display("FAIL midreset got cnt=%0d v=%b rdy=%b flit=%h want 0 0 1 0", count, out_if.valid, in_if.ready, out_if.flit);
            end
            mq.delete();
            m_ovf        = 1'b0;
            in_if.valid  = 1'b0;
            out_if.ready = 1'b0;
            recv_seq     = send_seq;
            r_prev       = 1'b1;
            @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk);
            #1;
         end
         in_if.valid = src_on && r_prev && ($urandom_range(3) != 0);
         in_if.flit  = W'(send_seq);
         if (in_if.valid) send_seq++;
         r_prev       = in_if.ready;
         out_if.ready = src_on ? 1'($urandom_range(1)) : 1'b1;
         if (out_if.valid && out_if.ready) begin
            checks++; if (out_if.flit !== W'(recv_seq)) begin errors++; $display("FAIL stream_seq got %h want %h", out_if.flit, W'(recv_seq)); end
            recv_seq++;
         end
         step();
         checks++; if (count !== 3'(mq.size()) || out_if.valid !== (mq.size() != 0) || out_if.flit !== exp_flit() || in_if.ready !== exp_ready()) begin
            errors++; $display("FAIL stream_state cyc=%0d got cnt=%0d v=%b flit=%h rdy=%b want cnt=%0d flit=%h rdy=%b",
                               cyc, count, out_if.valid, out_if.flit, in_if.ready, mq.size(), exp_flit(), exp_ready());
         end
         checks++; if (overflow !== 1'b0 || m_ovf) begin errors++; $display("FAIL stream_overflow cyc=%0d got %b want 0", cyc, overflow); end
      end
      checks++; if (recv_seq !== send_seq) begin errors++; $display("FAIL stream_delivered got %0d want %0d", recv_seq, send_seq); end
   endtask

   initial begin
      test_reset();
      test_single_flit();
      test_fill_drain();
      test_full_push_pop();
      test_overflow();
      test_random_stream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/noc_flit_if_skid_fifo.md
Name: noc_flit_if_skid_fifo

Overview:
- Flit buffer placed directly downstream of the registered-ready flit slicer, terminating a pipelined link.
- The upstream stage sees ready with registered latency, so it can present flits after ready has dropped. This block absorbs those in-flight flits in slack entries.
- It re-presents the buffered flits to the consumer (router input port or endpoint) on a standard valid/ready handshake.
- First-word-fall-through FIFO, no bypass path.

Parameters:
- CONFIG, NOC_DEFAULT_CONFIG, NoC configuration; flit type and width derive from it via noc_flit.svh.
- DEPTH, 4, number of flit entries; must be ≥ SLACK+1 and a power of two.
- SLACK, 2, entries kept free for in-flight flits; ready deasserts when free entries ≤ SLACK.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- flit_in_if  noc_flit_if.slave  -  incoming flits
  - valid is a push command.
  - ready is a stop hint with up to SLACK cycles of latency.
- flit_out_if  noc_flit_if.master  -  outgoing flits, standard valid/ready handshake.
- count  output  $clog2(DEPTH+1)  current occupancy
- overflow  output  1  sticky error flag: a flit arrived while the FIFO was full and not popping.

Behaviour:
- One clock domain (clk); reset is asynchronous, active-low (rst_n).
- Reset values:
  - count = 0; write/read pointers = 0; overflow = 0.
  - flit_out_if.valid = 0; flit_out_if.flit = 0; flit_in_if.ready = 1.
  - Storage array is not reset.
- Push and pop conditions:
  - push = flit_in_if.valid. It is independent of flit_in_if.ready, because the upstream slicer does not hold its flit when its registered ready is high.
  - pop = flit_out_if.valid && flit_out_if.ready.
- Registered status:
  - flit_in_if.ready is a registered output: next value = (DEPTH − count_next) > SLACK.
  - This gives upstream at least SLACK cycles of headroom.
- Write: on push with space (count < DEPTH, or pop in the same cycle), store the flit at the write pointer and increment it modulo DEPTH.
- Read/output:
  - flit_out_if.valid = (count != 0). flit_out_if.flit = entry at the read pointer (combinational read, FWFT).
  - On pop, increment the read pointer modulo DEPTH.
- Latency: a flit pushed at edge t is visible on flit_out_if at t+1. The minimum input-to-output latency is 1 cycle.
- count_next:
  - count + 1 on push-only; count − 1 on pop-only.
  - Unchanged on push+pop or idle; a push dropped by overflow counts as no push.
- Full (count == DEPTH):
  - push without pop: flit dropped, storage/pointers unchanged, overflow set to 1 until reset.
  - push with pop: both occur and count stays DEPTH.
- Empty (count == 0):
  - flit_out_if.valid = 0; a flit_out_if.ready assertion has no effect.
  - push with no pop yields count = 1. A same-cycle pass-through is not permitted.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Full/empty are decided by count, not pointer equality.
- Output stability: while flit_out_if.valid = 1 and ready = 0, flit_out_if.flit must not change.
- Reset mid-operation: all contents are discarded immediately, and outputs return to reset values asynchronously.
- Assertions:
  - overflow is never set when the upstream is the slicer with SLACK ≥ 2.
  - flit_out_if.valid is never asserted with count == 0.

Test Plan:
- Reset, then idle → count = 0, flit_out_if.valid = 0, flit_in_if.ready = 1, overflow = 0.
- Single flit A pushed at cycle 1, consumer ready = 1 → A on flit_out_if at cycle 2, popped; count 1 → 0.
- Consumer ready = 0, push 4 flits back-to-back (DEPTH = 4, SLACK = 2):
  - flit_in_if.ready falls after count reaches 2; all 4 are stored, count = 4, overflow = 0.
  - Release ready → flits drain in order 1, 2, 3, 4 on consecutive cycles.
- Full FIFO, simultaneous push and pop → count stays 4, head advances, pushed flit emerges last in order.
- Full FIFO, push with consumer ready = 0 → flit dropped, overflow = 1 and stays 1, existing 4 flits unchanged.
- Slicer plus this FIFO chained, random valid and random consumer ready for 10k cycles → every flit delivered exactly once, in order, overflow = 0; assert rst_n low mid-stream → count = 0, valid = 0 immediately.
